clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller that sequences start, stop and divide-ratio changes for a toggle-style divided clock.
- Changes are applied only at full-period boundaries, so no runt high or low phase is ever emitted.
- Sits between a register/config master (valid/ready handshake) and downstream logic clocked or enabled by the divided output.

Parameters:
- CNT_W, 8, width of half-period count and divide field.
- DIV_RST, 4, half-period value loaded into cur_div at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- en  in  1  run request; high = run divider, low = stop at next period end
- cfg_valid  in  1  new divide value offered
- cfg_ready  out  1  controller can accept cfg_div
- cfg_div  in  CNT_W  new half-period N (output period = 2N clk cycles); 0 = stop
- clk_out  out  1  divided clock
- tick  out  1  one-cycle pulse on the cycle clk_out rises (registered, coincident with clk_out 0->1)
- busy  out  1  high in RUN and DRAIN
- cur_div  out  CNT_W  half-period currently in effect

Behaviour:
- Reset: synchronous; when rst=0 at a posedge, the next state is IDLE, clk_out=0, tick=0, counter=0, pend_vld=0, cur_div=DIV_RST, cfg_ready=1, busy=0. Reset takes priority over everything, including mid-period operation.
- Handshake: transfer occurs when cfg_valid and cfg_ready are both high at a posedge. cfg_ready = !pend_vld. At most one pending value is held.
- IDLE:
  - Transfer applies cfg_div to cur_div at the next edge.
  - If en=1 and cur_div!=0: go to RUN, counter=0, clk_out=0.
  - A transfer and en=1 in the same cycle start with the OLD cur_div. The new value is used from the next period boundary; it is held as pending while RUN starts.
- RUN:
  - counter increments each cycle. When counter==cur_div-1: clk_out toggles and counter resets to 0.
  - Period boundary (PB) = cycle where counter==cur_div-1 and clk_out==1, i.e. the falling toggle.
  - Transfer in RUN stores the value in pending (pend_vld=1). A transfer on a PB cycle is NOT applied at that PB; it applies at the following one.
  - At PB with pend_vld: cur_div<=pending, pend_vld<=0, counter<=0. If the new value is 0, go to IDLE.
  - en=0 sampled in RUN: go to DRAIN; the current period completes unchanged.
- DRAIN: counting continues. At PB: clk_out falls, pending is applied if present, state goes to IDLE. If en returns to 1 before PB, go back to RUN without interruption.
- tick fires for every rising toggle. No tick is emitted in IDLE.
- N=1 gives clk_out = clk/2, toggling every cycle, with every second cycle a PB.
- Counter never exceeds cur_div-1. Arithmetic is unsigned CNT_W and never wraps.

Optional Feature:
- CLK_DIV_CTRL_CNT_EN defined: adds output port period_cnt [15:0]. It increments at each PB, wraps 0xFFFF->0, and is cleared by reset only.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package clk_div_pkg: state enum typedef (IDLE, RUN, DRAIN), default CNT_W constant, DIV_RST default constant.
- Sub-module clk_div_core: counter and toggle datapath with load/clear inputs, PB and rise outputs. clk_div_ctrl holds the FSM, pending register and handshake.

Test Plan:
- Reset then en=1 with cur_div=4 -> first clk_out rise 4 cycles after RUN entry, period 8, tick every 8 cycles, busy=1.
- Running N=4; cfg_div=2 accepted mid-high-phase -> cfg_ready=0 until next PB; following periods are 4 cycles, with no phase shorter than 2.
- cfg accepted exactly on a PB cycle -> that period is unaffected; new N applies at the next PB.
- en dropped while clk_out=1 with N=3 -> clk_out stays high for the remaining cycles of that phase, falls at PB, IDLE, busy=0, no further ticks.
- cfg_div=0 while running -> stop at next PB, clk_out=0, cur_div=0. en=1 afterwards stays IDLE until a nonzero value is written.
- rst=0 asserted mid-high-phase -> next edge clk_out=0, cur_div=DIV_RST, pend cleared; with CLK_DIV_CTRL_CNT_EN, period_cnt=0 and the bench checks wrap after 65536 PBs with N=1.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and default constants for the clk_div_ctrl programmable clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_RST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop for the divided clock; flags rising toggles and
// period boundaries (the falling toggle) back to the controller.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pb
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_tick;
  logic             w_hit;

  // i_div is never zero while i_run is high, so the decrement cannot wrap in use.
  assign w_hit  = (r_cnt == i_div - CNT_W'(1));
  assign o_pb   = i_run && w_hit && r_clk;
  assign o_clk  = r_clk;
  assign o_tick = r_tick;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
      end else if (i_run) begin
        if (w_hit) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: FSM, one-deep pending divide register and cfg handshake.
// Define CLK_DIV_CTRL_CNT_EN to add the 16-bit period_cnt output.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  state_t           r_state;
  logic             r_busy;
  logic             r_pendVld;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] r_curDiv;
  logic             w_xfer;
  logic             w_run;
  logic             w_pb;

  assign w_xfer    = cfg_valid && !r_pendVld;
  assign w_run     = (r_state != IDLE);
  assign cfg_ready = !r_pendVld;
  assign busy      = r_busy;
  assign cur_div   = r_curDiv;

  // Held cleared while idle so every start begins with a full low phase.
  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_run   (w_run),
    .i_clear (!w_run),
    .i_div   (r_curDiv),
    .o_clk   (clk_out),
    .o_tick  (tick),
    .o_pb    (w_pb)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_pendVld <= 1'b0;
      r_pend    <= '0;
      r_curDiv  <= CNT_W'(DIV_RST);
    end else begin
      case (r_state)
        IDLE: begin
          if (en && r_curDiv != '0) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            if (w_xfer) begin
              r_pend    <= cfg_div;
              r_pendVld <= 1'b1;
            end
          end else if (w_xfer) begin
            r_curDiv <= cfg_div;
          end else if (r_pendVld) begin
            r_curDiv  <= r_pend;
            r_pendVld <= 1'b0;
          end
        end
        default: begin
          // A value accepted on a boundary cycle waits for the next boundary.
          if (w_pb && r_pendVld) begin
            r_curDiv  <= r_pend;
            r_pendVld <= 1'b0;
          end else if (w_xfer) begin
            r_pend    <= cfg_div;
            r_pendVld <= 1'b1;
          end
          if (w_pb && ((r_pendVld && r_pend == '0) || !en)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= en ? RUN : DRAIN;
            r_busy  <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] r_periodCnt;

  assign period_cnt = r_periodCnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_periodCnt <= 16'd0;
    end else if (w_pb) begin
      r_periodCnt <= r_periodCnt + 16'd1;
    end
  end
`endif

endmodule
